// File: rtl/instr_fetch_unit_pkg.sv
// Shared types and constants for the decoupled instruction fetch stage.
// Queue entries carry the instruction together with its fetch address + 4.
package instr_fetch_unit_pkg;

    localparam int INSTR_W = 32;
    localparam int ADDR_W  = 32;

    localparam logic [INSTR_W-1:0] NOP_INSTR        = 32'h0;
    localparam logic [ADDR_W-1:0]  DEFAULT_RESET_PC = 32'h0;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [ADDR_W-1:0]  pc_plus4;
    } fetch_entry_t;

    function automatic logic [ADDR_W-1:0] next_word(input logic [ADDR_W-1:0] addr);
        return addr + ADDR_W'(4);
    endfunction

    function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] addr);
        return addr & ~ADDR_W'(3);
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// In-order prefetch queue of {instr, pc+4} entries with synchronous flush.
// Head is read combinationally; pointers carry one extra wrap bit.
module fetch_fifo
    import instr_fetch_unit_pkg::*;
#(
    parameter int  DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  fetch_entry_t     push_entry,
    output fetch_entry_t     head,
    output logic [PTR_W-1:0] count,
    output logic             empty,
    output logic             full
);

    fetch_entry_t     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign count   = wr_ptr - rd_ptr;
    assign empty   = (count == '0);
    assign full    = (count == PTR_W'(DEPTH));
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr[PTR_W-2:0]];

    // Flush wins over any push or pop in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem[wr_ptr[PTR_W-2:0]] <= push_entry;
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Decoupled IF stage: credit-limited word fetches over req/gnt/rvalid, in-order
// prefetch queue toward ID, and squash of in-flight fetches on a taken branch.
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic               clk_i,
    input  logic               rst_i,
    output logic               imem_req_o,
    output logic [ADDR_W-1:0]  imem_addr_o,
    input  logic               imem_gnt_i,
    input  logic               imem_rvalid_i,
    input  logic [INSTR_W-1:0] imem_rdata_i,
    input  logic               redirect_i,
    input  logic [ADDR_W-1:0]  redirect_pc_i,
    input  logic               stall_i,
    output logic               if_valid_o,
    output logic [INSTR_W-1:0] if_instr_o,
    output logic [ADDR_W-1:0]  if_pc_o
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int IDX_W = $clog2(DEPTH);

    // Handshakes: a fetch is transferred on a cycle with imem_req_o && imem_gnt_i;
    // each transferred fetch returns exactly one imem_rvalid_i, in request order.
    // Toward ID, the head entry is consumed on a cycle with if_valid_o && !stall_i.

    logic [ADDR_W-1:0] fetch_pc;
    logic [CNT_W-1:0]  outstanding;
    logic [CNT_W-1:0]  discard;
    logic [CNT_W:0]    in_flight;
    logic              fire;
    logic              rsp_ok;
    logic              rsp_keep;
    logic              q_pop;

    logic [ADDR_W-1:0] tag_mem [DEPTH];
    logic [IDX_W-1:0]  tag_wr;
    logic [IDX_W-1:0]  tag_rd;

    fetch_entry_t      push_entry;
    fetch_entry_t      q_head;
    logic [CNT_W-1:0]  q_count;
    logic              q_empty;
    logic              q_full;

    // Every buffered or in-flight fetch holds one queue slot, so a push never finds the queue full.
    assign in_flight   = {1'b0, q_count} + {1'b0, outstanding};
    assign imem_req_o  = rst_i && !redirect_i && (in_flight < (CNT_W+1)'(DEPTH));
    assign imem_addr_o = fetch_pc;
    assign fire        = imem_req_o && imem_gnt_i;
    assign rsp_ok      = imem_rvalid_i && (outstanding != '0);
    assign rsp_keep    = rsp_ok && (discard == '0) && !redirect_i;
    assign q_pop       = !q_empty && !stall_i && !redirect_i;

    assign push_entry.instr    = imem_rdata_i;
    assign push_entry.pc_plus4 = tag_mem[tag_rd];

    assign if_valid_o = !q_empty;
    assign if_instr_o = q_empty ? NOP_INSTR : q_head.instr;
    assign if_pc_o    = q_empty ? '0 : q_head.pc_plus4;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            fetch_pc <= RESET_PC;
        end else if (redirect_i) begin
            fetch_pc <= word_align(redirect_pc_i);
        end else if (fire) begin
            fetch_pc <= next_word(fetch_pc);
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            outstanding <= '0;
        end else begin
            outstanding <= outstanding + CNT_W'(fire) - CNT_W'(rsp_ok);
        end
    end

    // A redirect marks everything still in flight as stale; stacked redirects simply recount.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            discard <= '0;
        end else if (redirect_i) begin
            discard <= outstanding - CNT_W'(rsp_ok);
        end else if (rsp_ok && (discard != '0)) begin
            discard <= discard - CNT_W'(1);
        end
    end

    // Address tags follow every transferred fetch, stale or not, so they stay aligned with responses.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            tag_wr <= '0;
            tag_rd <= '0;
        end else begin
            if (fire) begin
                tag_wr <= tag_wr + IDX_W'(1);
            end
            if (rsp_ok) begin
                tag_rd <= tag_rd + IDX_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (fire) begin
            tag_mem[tag_wr] <= next_word(fetch_pc);
        end
    end

    fetch_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk       (clk_i),
        .rst_n     (rst_i),
        .push      (rsp_keep),
        .pop       (q_pop),
        .flush     (redirect_i),
        .push_entry(push_entry),
        .head      (q_head),
        .count     (q_count),
        .empty     (q_empty),
        .full      (q_full)
    );

    a_rvalid_in_flight: assert property (@(posedge clk_i) disable iff (!rst_i)
        !(imem_rvalid_i && (outstanding == '0)));

    a_no_push_when_full: assert property (@(posedge clk_i) disable iff (!rst_i)
        !(rsp_keep && q_full));

endmodule
